// File: rtl/pipe_pkg.sv
// Shared widths, field indices and helpers for the inter-stage result buffer.
package pipe_pkg;
  localparam int DATA_W = 32;
  localparam int NDATA  = 3;
  localparam int RD_W   = 6;
  localparam int WB_W   = 7;
  localparam int WE_BIT = 0;

  localparam int F_DMEM = 0;
  localparam int F_ALU  = 1;
  localparam int F_IMM  = 2;

  // Ceiling log2, never below 1 so that a stage index always has a bit.
  function automatic int clog2_min1(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/pipe_stage_buf_if.sv
// Bundle, control and hazard-query signals between the buffer and its neighbours.
interface pipe_stage_buf_if #(
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int NDATA  = pipe_pkg::NDATA,
  parameter int RD_W   = pipe_pkg::RD_W,
  parameter int WB_W   = pipe_pkg::WB_W,
  parameter int DEPTH  = 2
);
  import pipe_pkg::*;
  localparam int QS_W  = clog2_min1(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                    stall;
  logic                    flush;
  logic                    iValid;
  logic [NDATA*DATA_W-1:0] iData;
  logic [RD_W-1:0]         iRd;
  logic [WB_W-1:0]         iWB;
  logic                    iN;
  logic                    iZ;
  logic                    oValid;
  logic [NDATA*DATA_W-1:0] oData;
  logic [RD_W-1:0]         oRd;
  logic [WB_W-1:0]         oWB;
  logic                    oN;
  logic                    oZ;
  logic [CNT_W-1:0]        oCount;
  logic [RD_W-1:0]         qRd;
  logic                    qHit;
  logic [QS_W-1:0]         qHitStage;

  modport master (
    output stall, flush, iValid, iData, iRd, iWB, iN, iZ, qRd,
    input  oValid, oData, oRd, oWB, oN, oZ, oCount, qHit, qHitStage
  );

  modport slave (
    input  stall, flush, iValid, iData, iRd, iWB, iN, iZ, qRd,
    output oValid, oData, oRd, oWB, oN, oZ, oCount, qHit, qHitStage
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// One buffer stage: clears on reset/flush, holds on stall, loads otherwise.
module pipe_stage_reg #(
  parameter int DW   = pipe_pkg::NDATA * pipe_pkg::DATA_W,
  parameter int RD_W = pipe_pkg::RD_W,
  parameter int WB_W = pipe_pkg::WB_W
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            stall,
  input  logic            nxt_vld,
  input  logic [DW-1:0]   nxt_data,
  input  logic [RD_W-1:0] nxt_rd,
  input  logic [WB_W-1:0] nxt_wb,
  input  logic            nxt_n,
  input  logic            nxt_z,
  output logic            cur_vld,
  output logic [DW-1:0]   cur_data,
  output logic [RD_W-1:0] cur_rd,
  output logic [WB_W-1:0] cur_wb,
  output logic            cur_n,
  output logic            cur_z
);
  import pipe_pkg::*;

  // Bubbles load as all-zero so an invalid stage can never carry a write enable.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      cur_vld  <= 1'b0;
      cur_data <= '0;
      cur_rd   <= '0;
      cur_wb   <= '0;
      cur_n    <= 1'b0;
      cur_z    <= 1'b0;
    end else if (!stall) begin
      cur_vld  <= nxt_vld;
      cur_data <= nxt_vld ? nxt_data : '0;
      cur_rd   <= nxt_vld ? nxt_rd   : '0;
      cur_wb   <= nxt_vld ? nxt_wb   : '0;
      cur_n    <= nxt_vld & nxt_n;
      cur_z    <= nxt_vld & nxt_z;
    end
  end
endmodule

// File: rtl/pipe_stage_buf.sv
// DEPTH-stage EX/WB result buffer with stall, flush, occupancy and in-flight destination query.
module pipe_stage_buf #(
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int NDATA  = pipe_pkg::NDATA,
  parameter int RD_W   = pipe_pkg::RD_W,
  parameter int WB_W   = pipe_pkg::WB_W,
  parameter int DEPTH  = 2,
  parameter int WE_BIT = pipe_pkg::WE_BIT
) (
  input  logic            clock,
  input  logic            reset,
  pipe_stage_buf_if.slave bus
);
  import pipe_pkg::*;
  localparam int QS_W  = clog2_min1(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int DW    = NDATA * DATA_W;

  logic [DEPTH-1:0] vld, n, z;
  logic [DW-1:0]    data [DEPTH];
  logic [RD_W-1:0]  rd   [DEPTH];
  logic [WB_W-1:0]  wb   [DEPTH];

  logic [DEPTH-1:0] src_vld, src_n, src_z;
  logic [DW-1:0]    src_data [DEPTH];
  logic [RD_W-1:0]  src_rd   [DEPTH];
  logic [WB_W-1:0]  src_wb   [DEPTH];

  logic [CNT_W-1:0] cnt;
  logic             hit;
  logic [QS_W-1:0]  hit_stage;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign src_vld[k]  = bus.iValid;
      assign src_data[k] = bus.iData;
      assign src_rd[k]   = bus.iRd;
      assign src_wb[k]   = bus.iWB;
      assign src_n[k]    = bus.iN;
      assign src_z[k]    = bus.iZ;
    end else begin : g_link
      assign src_vld[k]  = vld[k-1];
      assign src_data[k] = data[k-1];
      assign src_rd[k]   = rd[k-1];
      assign src_wb[k]   = wb[k-1];
      assign src_n[k]    = n[k-1];
      assign src_z[k]    = z[k-1];
    end

    pipe_stage_reg #(.DW(DW), .RD_W(RD_W), .WB_W(WB_W)) u_reg (
      .clock    (clock),
      .reset    (reset),
      .flush    (bus.flush),
      .stall    (bus.stall),
      .nxt_vld  (src_vld[k]),
      .nxt_data (src_data[k]),
      .nxt_rd   (src_rd[k]),
      .nxt_wb   (src_wb[k]),
      .nxt_n    (src_n[k]),
      .nxt_z    (src_z[k]),
      .cur_vld  (vld[k]),
      .cur_data (data[k]),
      .cur_rd   (rd[k]),
      .cur_wb   (wb[k]),
      .cur_n    (n[k]),
      .cur_z    (z[k])
    );
  end

  // Scan oldest to newest so the youngest matching stage wins.
  always_comb begin
    cnt       = '0;
    hit       = 1'b0;
    hit_stage = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      cnt = cnt + CNT_W'(vld[k]);
      if (vld[k] && wb[k][WE_BIT] && (rd[k] == bus.qRd)) begin
        hit       = 1'b1;
        hit_stage = QS_W'(k);
      end
    end
  end

  assign bus.oValid    = vld[DEPTH-1];
  assign bus.oData     = data[DEPTH-1];
  assign bus.oRd       = rd[DEPTH-1];
  assign bus.oWB       = wb[DEPTH-1];
  assign bus.oN        = n[DEPTH-1];
  assign bus.oZ        = z[DEPTH-1];
  assign bus.oCount    = cnt;
  assign bus.qHit      = hit;
  assign bus.qHitStage = hit_stage;
endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf at DEPTH 2, 3 and 4 with directed scenarios and a queue reference model.
module tb_pipe_stage_buf;
  import pipe_pkg::*;

  typedef struct packed {
    logic                    v;
    logic [NDATA*DATA_W-1:0] d;
    logic [RD_W-1:0]         rd;
    logic [WB_W-1:0]         wb;
    logic                    n;
    logic                    z;
  } bun_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rst2, rst3, rst4;
  int   ntests = 0;
  int   nfail  = 0;
  bun_t z0 = '0;

  pipe_stage_buf_if #(.DEPTH(2)) b2 ();
  pipe_stage_buf_if #(.DEPTH(3)) b3 ();
  pipe_stage_buf_if #(.DEPTH(4)) b4 ();

  pipe_stage_buf #(.DEPTH(2)) u2 (.clock(clock), .reset(rst2), .bus(b2));
  pipe_stage_buf #(.DEPTH(3)) u3 (.clock(clock), .reset(rst3), .bus(b3));
  pipe_stage_buf #(.DEPTH(4)) u4 (.clock(clock), .reset(rst4), .bus(b4));

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic bun_t mk(input logic v, input logic [NDATA*DATA_W-1:0] d,
                              input logic [RD_W-1:0] rd, input logic [WB_W-1:0] wb,
                              input logic n, input logic z);
    bun_t b;
    b.v = v; b.d = d; b.rd = rd; b.wb = wb; b.n = n; b.z = z;
    return b;
  endfunction

  function automatic logic [NDATA*DATA_W-1:0] rnd_data();
    return {$urandom, $urandom, $urandom};
  endfunction

  task automatic drive(input int which, input bun_t b);
    case (which)
      2: begin b2.iValid = b.v; b2.iData = b.d; b2.iRd = b.rd; b2.iWB = b.wb; b2.iN = b.n; b2.iZ = b.z; end
      3: begin b3.iValid = b.v; b3.iData = b.d; b3.iRd = b.rd; b3.iWB = b.wb; b3.iN = b.n; b3.iZ = b.z; end
      default: begin b4.iValid = b.v; b4.iData = b.d; b4.iRd = b.rd; b4.iWB = b.wb; b4.iN = b.n; b4.iZ = b.z; end
    endcase
  endtask

  function automatic bun_t outb(input int which);
    case (which)
      2:       return {b2.oValid, b2.oData, b2.oRd, b2.oWB, b2.oN, b2.oZ};
      3:       return {b3.oValid, b3.oData, b3.oRd, b3.oWB, b3.oN, b3.oZ};
      default: return {b4.oValid, b4.oData, b4.oRd, b4.oWB, b4.oN, b4.oZ};
    endcase
  endfunction

  task automatic test_reset();
    rst2 = 1'b1; rst3 = 1'b1; rst4 = 1'b1;
    step(); step();
    rst2 = 1'b0; rst3 = 1'b0; rst4 = 1'b0;
    ntests++; if (outb(2) !== z0) begin nfail++; $display("FAIL reset_out_d2 got=%h exp=0", outb(2)); end
    ntests++; if (outb(3) !== z0) begin nfail++; $display("FAIL reset_out_d3 got=%h exp=0", outb(3)); end
    ntests++; if (outb(4) !== z0) begin nfail++; $display("FAIL reset_out_d4 got=%h exp=0", outb(4)); end
    ntests++; if (b2.oCount !== 2'd0 || b3.oCount !== 2'd0 || b4.oCount !== 3'd0) begin
      nfail++; $display("FAIL reset_count got=%0d/%0d/%0d exp=0", b2.oCount, b3.oCount, b4.oCount);
    end
    ntests++; if (b4.qHit !== 1'b0 || b4.qHitStage !== 2'd0) begin
      nfail++; $display("FAIL reset_query hit=%b stage=%0d exp=0/0", b4.qHit, b4.qHitStage);
    end
  endtask

  task automatic test_stream();
    bun_t a, c;
    bun_t exp_o [4];
    int   exp_c [4];
    a = mk(1'b1, {32'hC, 32'hB, 32'hA}, 6'd5, 7'h01, 1'b1, 1'b0);
    c = mk(1'b1, {32'h3, 32'h2, 32'h1}, 6'd6, 7'h03, 1'b0, 1'b1);
    exp_o = '{z0, a, c, z0};
    exp_c = '{1, 2, 1, 0};
    drive(2, a);
    for (int i = 0; i < 4; i++) begin
      step();
      ntests++; if (outb(2) !== exp_o[i]) begin nfail++; $display("FAIL stream_out[%0d] got=%h exp=%h", i, outb(2), exp_o[i]); end
      ntests++; if (b2.oCount !== exp_c[i][1:0]) begin nfail++; $display("FAIL stream_count[%0d] got=%0d exp=%0d", i, b2.oCount, exp_c[i]); end
      drive(2, (i == 0) ? c : z0);
    end
  endtask

  task automatic test_stall();
    drive(2, mk(1'b1, rnd_data(), 6'd3, 7'h01, 1'b0, 1'b0)); step();
    drive(2, mk(1'b1, rnd_data(), 6'd4, 7'h01, 1'b0, 1'b0)); step();
    b2.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(2, mk(1'b1, rnd_data(), 6'(10 + i), 7'h01, 1'b1, 1'b1));
      step();
      ntests++; if (b2.oRd !== 6'd3 || b2.oValid !== 1'b1 || b2.oCount !== 2'd2) begin
        nfail++; $display("FAIL stall_hold[%0d] rd=%0d vld=%b cnt=%0d exp=3/1/2", i, b2.oRd, b2.oValid, b2.oCount);
      end
    end
    b2.stall = 1'b0;
    drive(2, z0);
    step();
    ntests++; if (b2.oRd !== 6'd4 || b2.oValid !== 1'b1 || b2.oCount !== 2'd1) begin
      nfail++; $display("FAIL stall_release rd=%0d vld=%b cnt=%0d exp=4/1/1", b2.oRd, b2.oValid, b2.oCount);
    end
    step();
    ntests++; if (outb(2) !== z0 || b2.oCount !== 2'd0) begin
      nfail++; $display("FAIL stall_dropped got=%h cnt=%0d exp=0/0", outb(2), b2.oCount);
    end
  endtask

  task automatic test_flush_stall();
    drive(2, mk(1'b1, rnd_data(), 6'd11, 7'h01, 1'b1, 1'b0)); step();
    drive(2, mk(1'b1, rnd_data(), 6'd12, 7'h02, 1'b0, 1'b1)); step();
    ntests++; if (b2.oCount !== 2'd2) begin nfail++; $display("FAIL flush_fill cnt=%0d exp=2", b2.oCount); end
    b2.flush = 1'b1; b2.stall = 1'b1;
    drive(2, mk(1'b1, rnd_data(), 6'd20, 7'h7F, 1'b1, 1'b1));
    step();
    ntests++; if (b2.oValid !== 1'b0 || b2.oWB !== 7'd0 || b2.oCount !== 2'd0 || outb(2) !== z0) begin
      nfail++; $display("FAIL flush_clear got=%h cnt=%0d exp=0/0", outb(2), b2.oCount);
    end
    b2.flush = 1'b0; b2.stall = 1'b0;
    drive(2, z0);
    step(); step();
    ntests++; if (outb(2) !== z0 || b2.oCount !== 2'd0) begin
      nfail++; $display("FAIL flush_dropped got=%h cnt=%0d exp=0/0", outb(2), b2.oCount);
    end
  endtask

  task automatic test_query();
    int q  [3];
    int eh [3];
    int es [3];
    q = '{7, 9, 8}; eh = '{1, 1, 0}; es = '{0, 2, 0};
    drive(4, mk(1'b1, rnd_data(), 6'd9, 7'h01, 1'b0, 1'b0)); step();
    drive(4, mk(1'b1, rnd_data(), 6'd7, 7'h02, 1'b0, 1'b0)); step();
    drive(4, mk(1'b1, rnd_data(), 6'd7, 7'h05, 1'b0, 1'b0)); step();
    b4.stall = 1'b1;
    drive(4, z0);
    ntests++; if (b4.oCount !== 3'd3) begin nfail++; $display("FAIL query_fill cnt=%0d exp=3", b4.oCount); end
    for (int i = 0; i < 3; i++) begin
      b4.qRd = q[i][5:0];
      #1;
      ntests++; if (b4.qHit !== eh[i][0] || b4.qHitStage !== es[i][1:0]) begin
        nfail++; $display("FAIL query_rd%0d hit=%b stage=%0d exp=%0d/%0d", q[i], b4.qHit, b4.qHitStage, eh[i], es[i]);
      end
    end
    b4.stall = 1'b0;
  endtask

  task automatic test_bubble();
    rst4 = 1'b1; step(); rst4 = 1'b0;
    drive(4, mk(1'b0, rnd_data(), 6'd9, 7'h7F, 1'b1, 1'b1));
    step();
    b4.qRd = 6'd9;
    #1;
    ntests++; if (b4.qHit !== 1'b0 || b4.oCount !== 3'd0) begin
      nfail++; $display("FAIL bubble_query hit=%b cnt=%0d exp=0/0", b4.qHit, b4.oCount);
    end
    step(); step(); step();
    ntests++; if (outb(4) !== z0) begin nfail++; $display("FAIL bubble_out got=%h exp=0", outb(4)); end
    drive(4, z0);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive(3, mk(1'b1, rnd_data(), 6'(i + 1), 7'h01, 1'b1, 1'b1));
      step();
    end
    ntests++; if (b3.oCount !== 2'd3 || b3.oValid !== 1'b1) begin
      nfail++; $display("FAIL resetmid_fill cnt=%0d vld=%b exp=3/1", b3.oCount, b3.oValid);
    end
    b3.stall = 1'b1; rst3 = 1'b1;
    drive(3, mk(1'b1, rnd_data(), 6'd2, 7'h01, 1'b1, 1'b1));
    step();
    rst3 = 1'b0; b3.stall = 1'b0;
    b3.qRd = 6'd2;
    #1;
    ntests++; if (outb(3) !== z0 || b3.oCount !== 2'd0 || b3.qHit !== 1'b0) begin
      nfail++; $display("FAIL resetmid_clear got=%h cnt=%0d hit=%b exp=0/0/0", outb(3), b3.oCount, b3.qHit);
    end
    drive(3, z0);
  endtask

  task automatic test_random();
    bun_t m[$];
    bun_t in;
    logic r, f, s;
    logic [RD_W-1:0] q;
    int eh, es, ec;
    rst3 = 1'b1; step(); rst3 = 1'b0;
    m = '{z0, z0, z0};
    for (int c = 0; c < 300; c++) begin
      in = mk(1'($urandom_range(0, 1)), rnd_data(), 6'($urandom_range(0, 7)),
              7'($urandom), 1'($urandom), 1'($urandom));
      r = ($urandom_range(0, 49) == 0);
      f = ($urandom_range(0, 19) == 0);
      s = ($urandom_range(0, 4) == 0);
      q = 6'($urandom_range(0, 7));
      drive(3, in);
      rst3 = r; b3.flush = f; b3.stall = s; b3.qRd = q;
      #1;
      eh = 0; es = 0;
      for (int k = 0; k < 3; k++)
        if (eh == 0 && m[k].v && m[k].wb[WE_BIT] && m[k].rd == q) begin eh = 1; es = k; end
      ntests++; if (b3.qHit !== eh[0] || b3.qHitStage !== es[1:0]) begin
        nfail++; $display("FAIL rand_query[%0d] hit=%b stage=%0d exp=%0d/%0d", c, b3.qHit, b3.qHitStage, eh, es);
      end
      step();
      if (r || f) begin
        foreach (m[k]) m[k] = z0;
      end else if (!s) begin
        m.push_front(in.v ? in : z0);
        void'(m.pop_back());
      end
      ec = 0;
      foreach (m[k]) ec += int'(m[k].v);
      ntests++; if (outb(3) !== m[2]) begin nfail++; $display("FAIL rand_out[%0d] got=%h exp=%h", c, outb(3), m[2]); end
      ntests++; if (b3.oCount !== ec[1:0]) begin nfail++; $display("FAIL rand_count[%0d] got=%0d exp=%0d", c, b3.oCount, ec); end
    end
    rst3 = 1'b0; b3.flush = 1'b0; b3.stall = 1'b0;
  endtask

  initial begin
    rst2 = 1'b1; rst3 = 1'b1; rst4 = 1'b1;
    b2.stall = 1'b0; b2.flush = 1'b0; b2.qRd = '0;
    b3.stall = 1'b0; b3.flush = 1'b0; b3.qRd = '0;
    b4.stall = 1'b0; b4.flush = 1'b0; b4.qRd = '0;
    drive(2, z0); drive(3, z0); drive(4, z0);
    #2;
    test_reset();
    test_stream();
    test_stall();
    test_flush_stall();
    test_query();
    test_bubble();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
Parametrised inter-stage pipeline buffer: the next generation of the EX/WB result buffer. Carries data fields, destination register, writeback control and N/Z flags through DEPTH register stages. Adds a valid bit, stall (hold) and flush (bubble) control. Adds an in-flight destination query so hazard/forwarding logic can find pending register writes. Sits between the execute/memory stages and register-file writeback.

Parameters:
DATA_W, 32, width of one data field
NDATA, 3, number of data fields packed on iData/oData (field 0 = DMEM, 1 = ALU, 2 = immediate)
RD_W, 6, destination register address width
WB_W, 7, writeback control width
DEPTH, 2, number of register stages, legal range 1..8
WE_BIT, 0, index in WB of the register-write-enable bit
QS_W, max(1,clog2(DEPTH)), derived width of qHitStage; not user-set

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
stall  in  1  hold all stages
flush  in  1  invalidate all stages
iValid  in  1  input bundle is a real instruction
iData  in  NDATA*DATA_W  packed data fields, field k at bits [k*DATA_W +: DATA_W]
iRd  in  RD_W  destination register
iWB  in  WB_W  writeback control
iN, iZ  in  1 each  flags
oValid  out  1  output stage holds a real instruction
oData  out  NDATA*DATA_W  output data fields
oRd  out  RD_W  output destination
oWB  out  WB_W  output writeback control
oN, oZ  out  1 each  output flags
oCount  out  clog2(DEPTH+1)  number of valid stages
qRd  in  RD_W  hazard query register
qHit  out  1  some valid in-flight stage writes qRd
qHitStage  out  QS_W  youngest matching stage index (0 = newest)

Behaviour:
- Stages s[0..DEPTH-1]; each holds valid, data, rd, wb, n, z. Outputs o* are s[DEPTH-1] directly; no extra output register.
- Priority per posedge: reset > flush > stall > shift.
- reset: every stage field cleared to 0. oValid=0, oData=0, oRd=0, oWB=0, oN=oZ=0, oCount=0.
- flush: every stage field cleared to 0, same as reset. Input is dropped, even with stall high.
- stall (flush low): all stages hold; the input is not captured.
- shift: s[0] <= input; s[k] <= s[k-1].
- Bubble rule: if iValid=0 at capture, s[0] loads all zeros. An invalid stage therefore always has wb=0, so oWB!=0 implies oValid=1.
- Latency: a bundle captured at edge t appears on o* after edge t+DEPTH-1, i.e. DEPTH edges counting capture. With DEPTH=2, it is visible 2 cycles after being presented, matching the legacy buffer.
- oCount: registered or combinational popcount of valid bits; it must equal the popcount in the same cycle.
- Query (combinational): match[k] = s[k].valid & s[k].wb[WE_BIT] & (s[k].rd==qRd).
  - qHit = OR of match.
  - qHitStage = lowest k with match[k]; 0 when qHit=0.
  - Register 0 is not special.
- Stall while the output stage is valid: o* stays stable for the whole stall and writeback sees the same bundle repeatedly. Writeback gating is the consumer's job.
- DEPTH=1: single stage, qHitStage is a 1-bit constant 0.
- X-free: no output may be X after the first reset edge.

Decomposition:
- Shared package pipe_pkg: default widths (DATA_W, RD_W, WB_W), WE_BIT, NDATA field indices (F_DMEM, F_ALU, F_IMM), and a function clog2_min1.
- One sub-module, pipe_stage_reg: single stage with reset/flush/stall/load and bubble zeroing, instantiated DEPTH times via generate.
- Query/priority logic and popcount live in the top level.

Test Plan:
- Reset then stream, DEPTH=2: present iValid=1, iData fields {0xA,0xB,0xC}, iRd=5, iWB=0x01, iN=1 at cycle 0, then iValid=0 -> o* shows those values exactly 2 edges after presentation, then zeros; oCount goes 1,2,1,0.
- Stall: fill with rd=3 then rd=4, raise stall 3 cycles with new inputs changing -> oRd stays 3 for all 3 cycles; after release, oRd=4 next edge; inputs presented during stall are never seen.
- Flush with stall: with 2 valid stages, assert flush and stall together -> next edge oValid=0, oWB=0, oCount=0; input during flush is dropped.
- Hazard query, DEPTH=4: stages hold rd=7 (we=1) at s0, rd=7 (we=0) at s1, rd=9 (we=1) at s2. qRd=7 -> qHit=1, qHitStage=0. qRd=9 -> qHit=1, qHitStage=2. qRd=8 -> qHit=0, qHitStage=0.
- Bubble: iValid=0 with iWB=0x7F, iRd=9 -> that stage stores wb=0, and qRd=9 gives qHit=0.
- Reset mid-operation, DEPTH=3: full pipe, reset for 1 cycle while stall=1 -> all outputs 0 and oCount=0 at the next edge.
